// File: rtl/wr_route_pkg.sv
// rtl/wr_route_pkg.sv - shared target indices, state type and helpers for the write router
package wr_route_pkg;

    localparam int NUM_TGT   = 4;
    localparam int TGT_DMEM  = 0;
    localparam int TGT_MMIO  = 1;
    localparam int TGT_TIMER = 2;
    localparam int TGT_DBG   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [NUM_TGT-1:0] sel_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/wr_timeout_cnt.sv
// rtl/wr_timeout_cnt.sv - clearable SEND-cycle counter with terminal-count flag
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reload the count to zero (new request captured)
//   inc        : count one more cycle without acceptance
//   tc         : count has reached TIMEOUT-1 (always 0 when TIMEOUT == 0)
module wr_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;

    // The request is dropped as soon as tc is seen, so the count never
    // needs to go past TIMEOUT-1; with the timeout disabled it simply wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign tc = 1'b0;
        end else begin : g_on
            assign tc = (cnt == W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wr_demux_1x4.sv
// rtl/wr_demux_1x4.sv - one-source, four-target write router with timeout
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in_valid/in_ready               : source handshake
//   in_sel, in_addr, in_data, in_be : request target index and payload
//   out_valid[3:0] / out_ready[3:0] : one-hot per-target handshake
//   out_addr, out_data, out_be      : held payload shared by all targets
//   err_pulse, err_sel              : timeout pulse and sticky index of last timeout
//   done_cnt                        : per-target wrapping completion counters
module wr_demux_1x4
    import wr_route_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_sel,
    input  logic [DATA_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [3:0]             in_be,
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [DATA_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [3:0]             out_be,
    output logic                   err_pulse,
    output logic [1:0]             err_sel,
    output logic [4*CNT_W-1:0]     done_cnt
);

    state_t           state;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt_q [NUM_TGT];
    logic             accept;
    logic             capture;
    logic             tmo_tc;

    // Only the held target's ready matters; the others are ignored.
    assign accept   = (state == SEND) && out_ready[sel_q];
    // Pass-through ready in SEND lets a new request land on the accept edge.
    assign in_ready = (state == IDLE) ? 1'b1 : out_ready[sel_q];
    assign capture  = in_valid && in_ready;

    wr_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (capture),
        .inc   ((state == SEND) && !accept),
        .tc    (tmo_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_q     <= 2'd0;
            out_valid <= 4'b0000;
            out_addr  <= '0;
            out_data  <= '0;
            out_be    <= 4'b0000;
            err_pulse <= 1'b0;
            err_sel   <= 2'd0;
            for (int k = 0; k < NUM_TGT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            err_pulse <= 1'b0;

            if (accept) begin
                for (int k = 0; k < NUM_TGT; k++) begin
                    if (sel_q == 2'(k)) begin
                        cnt_q[k] <= cnt_q[k] + 1'b1;
                    end
                end
            end

            // Payload and sel are only sampled on a real capture, so an
            // undriven in_sel while in_valid is low never reaches the outputs.
            if (capture) begin
                state     <= SEND;
                sel_q     <= in_sel;
                out_valid <= sel_onehot(in_sel);
                out_addr  <= in_addr;
                out_data  <= in_data;
                out_be    <= in_be;
            end else begin
                case (state)
                    IDLE: begin
                        out_valid <= 4'b0000;
                    end
                    SEND: begin
                        if (accept) begin
                            state     <= IDLE;
                            out_valid <= 4'b0000;
                        end else if (tmo_tc) begin
                            // Acceptance takes priority, so this branch is a true drop.
                            state     <= IDLE;
                            out_valid <= 4'b0000;
                            err_pulse <= 1'b1;
                            err_sel   <= sel_q;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        out_valid <= 4'b0000;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_TGT; g++) begin : g_cnt
            assign done_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_wr_demux_1x4.sv
// tb/tb_wr_demux_1x4.sv - self-checking bench for wr_demux_1x4
module tb_wr_demux_1x4;

    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int CW  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_sel;
    logic [DW-1:0]   in_addr;
    logic [DW-1:0]   in_data;
    logic [3:0]      in_be;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [DW-1:0]   out_addr;
    logic [DW-1:0]   out_data;
    logic [3:0]      out_be;
    logic            err_pulse;
    logic [1:0]      err_sel;
    logic [4*CW-1:0] done_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt [4];

    wr_demux_1x4 #(.DATA_W(DW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_be     (in_be),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_be    (out_be),
        .err_pulse (err_pulse),
        .err_sel   (err_sel),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk(tag, 64'(done_cnt[k*CW +: CW]), 64'(exp_cnt[k] % (1 << CW)));
        end
    endtask

    // One request; target ready rises after `delay` SEND cycles, other
    // targets see `noise` on their ready lines the whole time.
    task automatic do_write(input logic [1:0] sel, input logic [DW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] be,
                            input int delay, input logic [3:0] noise);
        logic [3:0] oh;
        logic [3:0] nz;
        bit         accepted;
        oh = 4'b0001 << sel;
        nz = noise & ~oh;
        accepted = 0;
        @(negedge clk);
        out_ready = nz;
        in_valid  = 1'b1;
        in_sel    = sel;
        in_addr   = a;
        in_data   = d;
        in_be     = be;
        #1 chk("idle_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_sel   = 2'($urandom);
        in_addr  = $urandom;
        in_data  = $urandom;
        in_be    = 4'($urandom);
        for (int i = 0; i < TMO; i++) begin
            chk("out_valid", 64'(out_valid), 64'(oh));
            chk("out_addr", 64'(out_addr), 64'(a));
            chk("out_data", 64'(out_data), 64'(d));
            chk("out_be", 64'(out_be), 64'(be));
            if (i == delay) begin
                out_ready = nz | oh;
                #1 chk("pass_in_ready", 64'(in_ready), 64'(1));
                accepted = 1;
                @(negedge clk);
                break;
            end
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_err_pulse", 64'(err_pulse), 64'(0));
            @(negedge clk);
        end
        chk("post_out_valid", 64'(out_valid), 64'(0));
        out_ready = 4'b0000;
        if (accepted) begin
            exp_cnt[sel]++;
            chk("done_err_pulse", 64'(err_pulse), 64'(0));
        end else begin
            chk("tmo_err_pulse", 64'(err_pulse), 64'(1));
            chk("tmo_err_sel", 64'(err_sel), 64'(sel));
            @(negedge clk);
            chk("tmo_pulse_end", 64'(err_pulse), 64'(0));
            chk("tmo_err_sel_sticky", 64'(err_sel), 64'(sel));
        end
        check_counts("done_cnt");
    endtask

    initial begin
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_addr   = '0;
        in_data   = '0;
        in_be     = 4'h0;
        out_ready = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_err_pulse", 64'(err_pulse), 64'(0));
        chk("rst_err_sel", 64'(err_sel), 64'(0));
        chk("rst_done_cnt", 64'(done_cnt), 64'(0));
        chk("rst_out_addr", 64'(out_addr), 64'(0));
        chk("rst_out_be", 64'(out_be), 64'(0));
        rst_n = 1'b1;

        // Single write to the timer target.
        do_write(2'd2, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 0, 4'b0000);

        // Back-to-back to every target with all ready.
        @(negedge clk);
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_addr   = 32'hA000_0000;
        in_data   = 32'h0;
        in_be     = 4'h1;
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            chk("b2b_out_valid", 64'(out_valid), 64'(4'b0001 << (s - 1)));
            chk("b2b_out_data", 64'(out_data), 64'(s - 1));
            chk("b2b_in_ready", 64'(in_ready), 64'(1));
            if (s < 4) begin
                in_sel  = 2'(s);
                in_addr = 32'hA000_0000 + 32'(s);
                in_data = 32'(s);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        out_ready = 4'h0;
        chk("b2b_idle", 64'(out_valid), 64'(0));
        for (int k = 0; k < 4; k++) exp_cnt[k]++;
        check_counts("b2b_done_cnt");

        // Backpressure, wrong-target ready, timeout boundaries, recovery.
        do_write(2'd1, 32'h2000_0004, 32'h1234_5678, 4'h3, 5, 4'b0000);
        do_write(2'd0, 32'h0000_0100, 32'hCAFE_F00D, 4'hC, 3, 4'b1110);
        do_write(2'd3, 32'h3000_0000, 32'h5555_AAAA, 4'hF, 99, 4'b0111);
        do_write(2'd3, 32'h3000_0004, 32'h0F0F_0F0F, 4'h5, 0, 4'b0000);
        do_write(2'd2, 32'h4000_0000, 32'h7777_7777, 4'hA, TMO - 1, 4'b1011);

        // Randomized requests against the accept-before-timeout rule.
        for (int n = 0; n < 40; n++) begin
            do_write(2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom),
                     int'($urandom_range(0, TMO + 3)), 4'($urandom));
        end

        // 256 streamed writes to one target wrap its counter back to itself.
        @(negedge clk);
        out_ready = 4'b0001;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        for (int n = 0; n < 255; n++) begin
            @(negedge clk);
            in_data = 32'(n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 4'h0;
        exp_cnt[0] += 256;
        check_counts("wrap_done_cnt");

        // Reset while a request is pending on MMIO.
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(out_valid), 64'(4'b0010));
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_done_cnt", 64'(done_cnt), 64'(0));
        chk("mid_rst_err_sel", 64'(err_sel), 64'(0));
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_write(2'd1, 32'h2000_0008, 32'h8765_4321, 4'hF, 2, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wr_demux_1x4.md
Name: wr_demux_1x4

Overview:
- One-source, four-destination write router: the inverse of the datapath's 4:1 result select.
- Accepts one write (addr/data/byte-enable plus a 2-bit target select) from the core-side store path and delivers it to exactly one of four targets (data memory, MMIO/GPIO, timer, debug/UART) over a valid/ready handshake.
- Holds one request in a register, supports back-to-back throughput, and aborts any transfer that a target leaves unaccepted for too long.

Parameters:
- DATA_W, 32, width of the address and data buses.
- TIMEOUT, 16, number of SEND cycles without target acceptance before the request is dropped; 0 disables the timeout.
- CNT_W, 8, width of the per-target completion counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source request valid.
- in_ready  output  1  router can accept a request this cycle.
- in_sel  input  2  destination index 0..3.
- in_addr  input  DATA_W  write address.
- in_data  input  DATA_W  write data.
- in_be  input  4  byte enables.
- out_valid  output  4  one-hot request valid per target.
- out_ready  input  4  per-target accept.
- out_addr  output  DATA_W  held address, shared by all targets.
- out_data  output  DATA_W  held data, shared by all targets.
- out_be  output  4  held byte enables, shared by all targets.
- err_pulse  output  1  one-cycle pulse when a request times out.
- err_sel  output  2  target index of the last timeout; sticky until the next timeout.
- done_cnt  output  4*CNT_W  completed-transfer counter per target (target k in bits [k*CNT_W +: CNT_W]), wrapping.

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0; out_addr, out_data, out_be, held sel = 0; err_pulse=0; err_sel=0; all done_cnt=0; timeout counter=0.
- Handshake: a transfer occurs on a rising edge where valid&ready are both 1. Once out_valid[k] is asserted, it and the held payload stay stable until acceptance or timeout.
- FSM state IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture sel/addr/data/be; go to SEND; clear the timeout counter.
- FSM state SEND:
  - out_valid = one-hot(held sel).
  - in_ready = out_ready[held sel], which gives pass-through so back-to-back requests see no bubble.
  - Accept edge (out_ready[held sel]=1): done_cnt[held sel] +1, wrapping at 2^CNT_W.
    - If in_valid is also 1, capture the new request and stay in SEND with the counter cleared (the new target may equal or differ from the old one).
    - Otherwise go to IDLE.
  - No acceptance: increment the timeout counter. When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no acceptance:
    - drop the request, err_pulse=1 for the next cycle, err_sel=held sel;
    - go to IDLE with in_ready=0 during that timeout cycle;
    - the dropped request does not increment done_cnt.
  - Acceptance on the same cycle as the timeout threshold: acceptance wins, with no error.
- Latency: in_valid at cycle N (router idle) gives out_valid at N+1; sustained throughput is 1 write/cycle while the target holds ready.
- out_ready bits of non-selected targets are ignored, and out_valid is never multi-hot.
- Reset asserted mid-SEND: the request is discarded immediately and out_valid drops asynchronously.
- X on in_sel while in_valid=0 must not propagate; the payload is captured only on the accept edge.

Decomposition:
- Shared package wr_route_pkg:
  - target index localparams TGT_DMEM=0, TGT_MMIO=1, TGT_TIMER=2, TGT_DBG=3;
  - state enum {IDLE, SEND}.
- One natural sub-module: wr_timeout_cnt, a loadable down/up counter with a terminal-count output, parameterised by TIMEOUT.

Test Plan:
- Single write: in_sel=2, addr=0x1000_0040, data=0xDEADBEEF, be=0xF, out_ready=4'b0100 → out_valid=4'b0100 one cycle later, payload exact, done_cnt[2]=1, back to IDLE.
- Back-to-back: 4 consecutive writes sel=0,1,2,3 with all out_ready=1 → one completion per cycle, no in_ready bubble, each done_cnt=1.
- Backpressure: sel=1, out_ready[1] low for 5 cycles then high → payload stable 6 cycles, in_ready=0 for 5 cycles, exactly one completion.
- Timeout: TIMEOUT=16, sel=3, out_ready=0 → on the 16th SEND cycle request dropped, err_pulse=1 one cycle, err_sel=3, done_cnt[3]=0; a subsequent write is accepted normally.
- Wrong-target ready: sel=0, out_ready=4'b1110 → no acceptance, out_valid stays 4'b0001.
- Reset mid-SEND: assert rst_n=0 while out_valid=4'b0010 → out_valid=0 immediately, counters zero, IDLE after release.
